// File: rtl/conv_mac_scheduler.sv
// conv_mac_scheduler: walks a valid 2-D convolution through one shared FP
// multiplier and one shared FP adder, one kernel tap at a time.
// Optional feature macro: CONV_MAC_BIAS_EN (adds a bias port used as the
// per-pixel accumulator seed instead of +0.0).
module conv_mac_scheduler #(
   parameter int imageWidth  = 5,
   parameter int imageHeight = 5,
   parameter int kernalSize  = 3,
   parameter int wordlength  = 32,
   localparam int OW  = imageWidth - kernalSize + 1,
   localparam int OH  = imageHeight - kernalSize + 1,
   localparam int IAW = (imageWidth*imageHeight > 1) ? $clog2(imageWidth*imageHeight) : 1,
   localparam int KAW = (kernalSize*kernalSize > 1) ? $clog2(kernalSize*kernalSize) : 1,
   localparam int RAW = (OW*OH > 1) ? $clog2(OW*OH) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
`ifdef CONV_MAC_BIAS_EN
   input  logic [wordlength-1:0] bias,
`endif
   output logic                  busy,
   output logic                  done,
   output logic [IAW-1:0]        img_addr,
   input  logic [wordlength-1:0] img_data,
   output logic [KAW-1:0]        ker_addr,
   input  logic [wordlength-1:0] ker_data,
   output logic [wordlength-1:0] mul_a_tdata,
   output logic [wordlength-1:0] mul_b_tdata,
   output logic                  mul_tvalid,
   input  logic                  mul_res_tvalid,
   input  logic [wordlength-1:0] mul_res_tdata,
   output logic [wordlength-1:0] add_a_tdata,
   output logic [wordlength-1:0] add_b_tdata,
   output logic                  add_tvalid,
   input  logic                  add_res_tvalid,
   input  logic [wordlength-1:0] add_res_tdata,
   output logic [RAW-1:0]        res_addr,
   output logic [wordlength-1:0] res_data,
   output logic                  res_we
);

   localparam int CW = 16;

   typedef enum logic [3:0] {
      IDLE, RD, WT, MUL_ISS, MUL_WT, ADD_ISS, ADD_WT, WR, DONE
   } state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         row_q, row_d, col_q, col_d, ik_q, ik_d, jk_q, jk_d;
   logic [wordlength-1:0] opk_q, opk_d, opi_q, opi_d, prod_q, prod_d, acc_q, acc_d;
   logic [wordlength-1:0] seed;   // accumulator value at the start of each pixel
   logic                  last_tap, last_col, last_row;

`ifdef CONV_MAC_BIAS_EN
   logic [wordlength-1:0] bias_q, bias_d;
   assign seed = bias_q;
`else
   assign seed = '0;
`endif

   assign last_tap = (ik_q == CW'(kernalSize-1)) && (jk_q == CW'(kernalSize-1));
   assign last_col = (col_q == CW'(OW-1));
   assign last_row = (row_q == CW'(OH-1));

   // Outputs decoded from state and registers; all are zero under reset.
   assign busy        = (state_q != IDLE) && (state_q != DONE);
   assign done        = (state_q == DONE);
   assign img_addr    = IAW'((32'(row_q) + 32'(ik_q)) * 32'(imageWidth) + 32'(col_q) + 32'(jk_q));
   assign ker_addr    = KAW'(32'(ik_q) * 32'(kernalSize) + 32'(jk_q));
   assign mul_a_tdata = opk_q;
   assign mul_b_tdata = opi_q;
   assign mul_tvalid  = (state_q == MUL_ISS);
   assign add_a_tdata = prod_q;
   assign add_b_tdata = acc_q;
   assign add_tvalid  = (state_q == ADD_ISS);
   assign res_addr    = RAW'(32'(row_q) * 32'(OW) + 32'(col_q));
   assign res_data    = acc_q;
   assign res_we      = (state_q == WR);

   // State, counters and datapath registers; reset discards any partial pixel.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         row_q   <= '0;
         col_q   <= '0;
         ik_q    <= '0;
         jk_q    <= '0;
         opk_q   <= '0;
         opi_q   <= '0;
         prod_q  <= '0;
         acc_q   <= '0;
`ifdef CONV_MAC_BIAS_EN
         bias_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
         ik_q    <= ik_d;
         jk_q    <= jk_d;
         opk_q   <= opk_d;
         opi_q   <= opi_d;
         prod_q  <= prod_d;
         acc_q   <= acc_d;
`ifdef CONV_MAC_BIAS_EN
         bias_q  <= bias_d;
`endif
      end
   end

   // Next-state: one tap is read, multiplied, then folded into acc in turn.
   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      ik_d    = ik_q;
      jk_d    = jk_q;
      opk_d   = opk_q;
      opi_d   = opi_q;
      prod_d  = prod_q;
      acc_d   = acc_q;
`ifdef CONV_MAC_BIAS_EN
      bias_d  = bias_q;
`endif
      case (state_q)
         IDLE: if (start) begin
            state_d = RD;
            row_d   = '0;
            col_d   = '0;
            ik_d    = '0;
            jk_d    = '0;
`ifdef CONV_MAC_BIAS_EN
            bias_d  = bias;
            acc_d   = bias;
`else
            acc_d   = '0;
`endif
         end
         RD:      state_d = WT;
         WT: begin
            opk_d   = ker_data;
            opi_d   = img_data;
            state_d = MUL_ISS;
         end
         MUL_ISS: state_d = MUL_WT;
         MUL_WT: if (mul_res_tvalid) begin
            prod_d  = mul_res_tdata;
            state_d = ADD_ISS;
         end
         ADD_ISS: state_d = ADD_WT;
         ADD_WT: if (add_res_tvalid) begin
            acc_d = add_res_tdata;
            if (last_tap) begin
               state_d = WR;
            end else begin
               state_d = RD;
               if (jk_q == CW'(kernalSize-1)) begin
                  jk_d = '0;
                  ik_d = ik_q + 1'b1;
               end else begin
                  jk_d = jk_q + 1'b1;
               end
            end
         end
         WR: begin
            acc_d = seed;
            ik_d  = '0;
            jk_d  = '0;
            if (last_col) begin
               col_d = '0;
               row_d = row_q + 1'b1;
            end else begin
               col_d = col_q + 1'b1;
            end
            state_d = (last_col && last_row) ? DONE : RD;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

endmodule
